// File: rtl/mem_loader.sv
// Host memory front end: framed I/D loads, 'G' run hand-off, done-triggered data-memory dump.
// Optional macro MEM_LOADER_CSUM_EN adds an XOR checksum reply byte after every I/D frame.
module mem_loader #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] DONE_ADDR = {ADDR_W{1'b1}},
  parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
  parameter logic [15:0]     DUMP_LEN  = 16'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cpu_hold,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [15:0]       proc_wdata,
  input  logic              proc_dm_wr,
  input  logic              proc_im_wr,
  output logic [7:0]        proc_dm_in,
  output logic [7:0]        proc_im_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              dm_we,
  output logic              im_we,
  input  logic [7:0]        dm_rdata,
  input  logic [7:0]        im_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA    = 3'd3,
`ifdef MEM_LOADER_CSUM_EN
    S_CSUM    = 3'd4,
`endif
    S_RUN     = 3'd5,
    S_DUMP_RD = 3'd6,
    S_DUMP_TX = 3'd7
  } state_t;

`ifdef MEM_LOADER_CSUM_EN
  localparam state_t FRAME_END = S_CSUM;
`else
  localparam state_t FRAME_END = S_IDLE;
`endif

  state_t            state;
  logic              sel_im;
  logic [7:0]        len_hi;
  logic [15:0]       remain;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       dump_idx;
  logic              dump_first;
  logic [7:0]        dump_byte;
  logic              rx_fire;
  logic              done_hit;
  logic [ADDR_W-1:0] dump_addr;
  logic              unused_wdata_hi;

  assign rx_fire   = rx_valid && rx_ready;
  assign done_hit  = (state == S_RUN) && proc_dm_wr && (proc_addr == DONE_ADDR);
  assign dump_addr = DUMP_BASE + dump_idx[ADDR_W-1:0];
  assign unused_wdata_hi = ^proc_wdata[15:8];

  assign rx_ready = (state == S_IDLE) || (state == S_LEN_HI) ||
                    (state == S_LEN_LO) || (state == S_DATA);
  assign cpu_hold = (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel_im     <= 1'b0;
      len_hi     <= 8'd0;
      remain     <= 16'd0;
      load_addr  <= '0;
      dump_idx   <= 16'd0;
      dump_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (rx_fire) begin
          case (rx_data)
            8'h49:   begin sel_im <= 1'b1; state <= S_LEN_HI; end
            8'h44:   begin sel_im <= 1'b0; state <= S_LEN_HI; end
            8'h47:   state <= S_RUN;
            default: state <= S_IDLE;
          endcase
        end
        S_LEN_HI: if (rx_fire) begin
          len_hi <= rx_data;
          state  <= S_LEN_LO;
        end
        S_LEN_LO: if (rx_fire) begin
          remain    <= {len_hi, rx_data};
          load_addr <= '0;
          state     <= ({len_hi, rx_data} == 16'd0) ? FRAME_END : S_DATA;
        end
        S_DATA: if (rx_fire) begin
          load_addr <= load_addr + 1'b1;
          remain    <= remain - 16'd1;
          if (remain == 16'd1) state <= FRAME_END;
        end
`ifdef MEM_LOADER_CSUM_EN
        S_CSUM: if (tx_ready) state <= S_IDLE;
`endif
        S_RUN: if (done_hit) begin
          dump_idx <= 16'd0;
          state    <= (DUMP_LEN == 16'd0) ? S_IDLE : S_DUMP_RD;
        end
        S_DUMP_RD: begin
          dump_first <= 1'b1;
          state      <= S_DUMP_TX;
        end
        S_DUMP_TX: begin
          dump_first <= 1'b0;
          if (tx_ready) begin
            dump_idx <= dump_idx + 16'd1;
            state    <= (dump_idx + 16'd1 == DUMP_LEN) ? S_IDLE : S_DUMP_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // dm_rdata is live on the first DUMP_TX cycle; hold it so a stalled byte stays put
  always_ff @(posedge clk) begin
    if (state == S_DUMP_TX && dump_first) dump_byte <= dm_rdata;
  end

`ifdef MEM_LOADER_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst)                          csum <= 8'd0;
    else if (state == S_IDLE && rx_fire) csum <= 8'd0;
    else if (state == S_DATA && rx_fire) csum <= csum ^ rx_data;
  end
`endif

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    if (state == S_DUMP_TX) begin
      tx_valid = 1'b1;
      tx_data  = dump_first ? dm_rdata : dump_byte;
    end
`ifdef MEM_LOADER_CSUM_EN
    if (state == S_CSUM) begin
      tx_valid = 1'b1;
      tx_data  = csum;
    end
`endif
  end

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    dm_we      = 1'b0;
    im_we      = 1'b0;
    proc_dm_in = 8'd0;
    proc_im_in = 8'd0;
    case (state)
      S_DATA: begin
        mem_addr  = load_addr;
        mem_wdata = rx_data;
        dm_we     = rx_fire && !sel_im;
        im_we     = rx_fire && sel_im;
      end
      S_RUN: begin
        mem_addr   = proc_addr;
        mem_wdata  = proc_wdata[7:0];
        dm_we      = proc_dm_wr && !done_hit;
        im_we      = proc_im_wr;
        proc_dm_in = dm_rdata;
        proc_im_in = im_rdata;
      end
      S_DUMP_RD, S_DUMP_TX: mem_addr = dump_addr;
      default: ;
    endcase
  end

endmodule
